led_code_scanner: RTL and testbench
===================================

LED_CODE_SCANNER -- requirements
Module: led_code_scanner

Interface
REQ-001 SHALL have parameter TABLE_W, default 16: code table width in bits, an integer multiple of LED_W.
REQ-002 SHALL have parameter LED_W, default 4: LED slice width in bits; NS = TABLE_W/LED_W slices.
REQ-003 SHALL have parameter DIV, default 16281: CLK cycles per display tick (DIV >= 2).
REQ-004 SHALL have parameter DWELL, default 381: ticks each slice is shown (DWELL >= 1).
REQ-005 SHALL have parameter GAP, default 0: blank ticks after each slice; 0 means no blanking.
REQ-006 SHALL have parameter PASSES, default 2: full table passes per run; 0 means continuous until ABORT.
REQ-007 SHALL have port CLK, input, 1 bit: clock, all state on rising edge.
REQ-008 SHALL have port nRST, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port START, input, 1 bit: run request, sampled in IDLE only.
REQ-010 SHALL have port ABORT, input, 1 bit: terminate the run in progress.
REQ-011 SHALL have port TABLE, input, TABLE_W bits: code table, captured on an accepted START.
REQ-012 SHALL have port LED_DATA, output, LED_W bits, registered: displayed slice.
REQ-013 SHALL have port SLICE_IDX, output, max(1,clog2(NS)) bits, registered: index of the current slice.
REQ-014 SHALL have port BUSY, output, 1 bit, registered: high while not IDLE.
REQ-015 SHALL have port DONE, output, 1 bit, registered: one-cycle pulse on normal completion.

Function
REQ-016 SHALL be a single clock domain: the prescaler produces a one-cycle tick enable, never a derived clock.
REQ-017 SHALL implement states IDLE, SHOW and BLANK.
REQ-018 SHALL accept START in IDLE by:
- capturing TABLE into a shadow register;
- clearing prescaler, dwell counter, slice counter and pass counter;
- loading LED_DATA with shadow[LED_W-1:0] and setting SLICE_IDX=0, BUSY=1;
- entering SHOW, all on the same edge.
REQ-019 SHALL run the prescaler 0..DIV-1 while BUSY, with tick asserted in the cycle where count==DIV-1; the first tick falls DIV edges after the accepted START.
REQ-020 SHALL, in SHOW, count ticks; on the DWELL-th tick go to BLANK with LED_DATA=0 if GAP>0, otherwise advance the slice.
REQ-021 SHALL, in BLANK, count ticks; on the GAP-th tick advance the slice.
REQ-022 SHALL advance the slice by setting slice+1 and LED_DATA=shadow[(slice+1)*LED_W +: LED_W] (LSB slice first), then entering SHOW.
REQ-023 SHALL, when advancing past slice NS-1, wrap to slice 0 and increment the pass counter.
REQ-024 SHALL, if PASSES!=0 and the completed pass is number PASSES:
- go to IDLE;
- drive LED_DATA=0, SLICE_IDX=0, BUSY=0;
- pulse DONE=1 for exactly one cycle, on that same edge.
REQ-025 SHALL hold the pass counter at its value when PASSES==0 (no overflow), running until ABORT.
REQ-026 SHALL ignore START while BUSY, and ignore TABLE changes after capture.
REQ-027 SHALL treat ABORT while BUSY as highest priority: next edge IDLE, LED_DATA=0, SLICE_IDX=0, BUSY=0, DONE=0, including on a final-tick edge.
REQ-028 SHALL ignore ABORT in IDLE; START and ABORT together in IDLE SHALL start a run.
REQ-029 SHALL hold DONE=0 at all times other than REQ-024.

Reset
REQ-030 SHALL, on nRST low at any time (mid-run included), immediately force state=IDLE, LED_DATA=0, SLICE_IDX=0, BUSY=0, DONE=0, and clear all counters and the shadow register.
REQ-031 SHALL require a new START after nRST release; no run resumes.

Verification
REQ-032 SHALL be covered with DIV=4, DWELL=3, GAP=1, PASSES=1, TABLE=16'hA5C3, START at edge 0:
- LED_DATA reads 3 over edges 0-11, 0 over 12-15, C over 16-27, then 0, 5, 0, A;
- DONE=1 and BUSY=0 after edge 64 only.
REQ-033 SHALL be covered with GAP=0, PASSES=2, same table: sequence 3,C,5,A,3,C,5,A with 12 cycles per slice, no blank, DONE after edge 96.
REQ-034 SHALL be covered with PASSES=0: run for more than 5 passes, slice order repeating and no DONE; then ABORT -> next edge LED_DATA=0, BUSY=0, DONE=0.
REQ-035 SHALL be covered with START re-pulsed and TABLE changed to 16'hFFFF mid-run: no restart, and the original nibbles are displayed.
REQ-036 SHALL be covered with nRST low mid-slice: outputs zero immediately; after release, START with TABLE=16'h1234 gives the first nibble 4.
REQ-037 SHALL be covered with TABLE_W=24, LED_W=8: three slices shown LSB byte first and SLICE_IDX counting 0,1,2.

Source files
------------

// File: rtl/led_code_scanner.sv
// Multiplexed LED code scanner: shows a captured code table one slice at a time,
// LSB slice first, with optional blank gaps and a fixed or unbounded number of passes.
module led_code_scanner #(
    parameter int TABLE_W = 16,
    parameter int LED_W   = 4,
    parameter int DIV     = 16281,
    parameter int DWELL   = 381,
    parameter int GAP     = 0,
    parameter int PASSES  = 2,
    localparam int unsigned NS = TABLE_W / LED_W,
    localparam int IW = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               START,
    input  logic               ABORT,
    input  logic [TABLE_W-1:0] TABLE,
    output logic [LED_W-1:0]   LED_DATA,
    output logic [IW-1:0]      SLICE_IDX,
    output logic               BUSY,
    output logic               DONE
);

    localparam int PW      = $clog2(DIV);
    localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PSW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [PW-1:0]  DIV_LAST   = PW'(DIV - 1);
    localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0]  GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [PSW-1:0] PASS_LAST  = PSW'((PASSES > 0) ? PASSES - 1 : 0);
    localparam logic [IW-1:0]  SLICE_LAST = IW'(NS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t             state_q;
    logic [TABLE_W-1:0] shadow_q;
    logic [PW-1:0]      presc_q;
    logic [CW-1:0]      cnt_q;
    logic [IW-1:0]      slice_q;
    logic [PSW-1:0]     pass_q;
    logic [LED_W-1:0]   led_q;
    logic               busy_q;
    logic               done_q;

    logic               tick;
    logic               seg_end;
    logic               wrap;
    logic               run_done;
    logic [IW-1:0]      slice_d;
    logic [LED_W-1:0]   led_d;

    always_comb begin
        tick     = (state_q != IDLE) && (presc_q == DIV_LAST);
        seg_end  = tick && (cnt_q == ((state_q == BLANK) ? GAP_LAST : DWELL_LAST));
        wrap     = (slice_q == SLICE_LAST);
        run_done = wrap && (PASSES != 0) && (pass_q == PASS_LAST);
        slice_d  = wrap ? '0 : slice_q + 1'b1;
        led_d    = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            if (slice_d == IW'(i)) led_d = shadow_q[i*LED_W +: LED_W];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            slice_q  <= '0;
            pass_q   <= '0;
            led_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // ABORT has no meaning here, so START alone decides
                    if (START) begin
                        state_q  <= SHOW;
                        shadow_q <= TABLE;
                        presc_q  <= '0;
                        cnt_q    <= '0;
                        slice_q  <= '0;
                        pass_q   <= '0;
                        led_q    <= TABLE[LED_W-1:0];
                        busy_q   <= 1'b1;
                    end
                end
                default: begin
                    if (ABORT) begin
                        state_q <= IDLE;
                        presc_q <= '0;
                        cnt_q   <= '0;
                        slice_q <= '0;
                        led_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        presc_q <= tick ? '0 : presc_q + 1'b1;
                        if (seg_end) begin
                            cnt_q <= '0;
                            if (state_q == SHOW && GAP > 0) begin
                                state_q <= BLANK;
                                led_q   <= '0;
                            end else if (run_done) begin
                                state_q <= IDLE;
                                presc_q <= '0;
                                slice_q <= '0;
                                led_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= SHOW;
                                slice_q <= slice_d;
                                led_q   <= led_d;
                                // Unbounded runs leave the pass count parked
                                if (wrap && PASSES != 0) pass_q <= pass_q + 1'b1;
                            end
                        end else if (tick) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign LED_DATA  = led_q;
    assign SLICE_IDX = slice_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_led_code_scanner.sv
// Bench for led_code_scanner: four parameterisations checked edge by edge against
// an arithmetic timeline model of the display sequence.
module tb_led_code_scanner;

    typedef struct packed {
        logic [7:0] led;
        logic [1:0] idx;
        logic       busy;
        logic       done;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic        start_a, abort_a, busy_a, done_a;
    logic [15:0] table_a;
    logic [3:0]  led_a;
    logic [1:0]  idx_a;
    logic        start_b, abort_b, busy_b, done_b;
    logic [15:0] table_b;
    logic [3:0]  led_b;
    logic [1:0]  idx_b;
    logic        start_c, abort_c, busy_c, done_c;
    logic [15:0] table_c;
    logic [3:0]  led_c;
    logic [1:0]  idx_c;
    logic        start_d, abort_d, busy_d, done_d;
    logic [23:0] table_d;
    logic [7:0]  led_d;
    logic [1:0]  idx_d;

    int checks = 0;
    int fails  = 0;

    led_code_scanner #(.TABLE_W(16), .LED_W(4), .DIV(4), .DWELL(3), .GAP(1), .PASSES(1)) u_a (
        .CLK(CLK), .nRST(nRST), .START(start_a), .ABORT(abort_a), .TABLE(table_a),
        .LED_DATA(led_a), .SLICE_IDX(idx_a), .BUSY(busy_a), .DONE(done_a));
    led_code_scanner #(.TABLE_W(16), .LED_W(4), .DIV(4), .DWELL(3), .GAP(0), .PASSES(2)) u_b (
        .CLK(CLK), .nRST(nRST), .START(start_b), .ABORT(abort_b), .TABLE(table_b),
        .LED_DATA(led_b), .SLICE_IDX(idx_b), .BUSY(busy_b), .DONE(done_b));
    led_code_scanner #(.TABLE_W(16), .LED_W(4), .DIV(4), .DWELL(3), .GAP(1), .PASSES(0)) u_c (
        .CLK(CLK), .nRST(nRST), .START(start_c), .ABORT(abort_c), .TABLE(table_c),
        .LED_DATA(led_c), .SLICE_IDX(idx_c), .BUSY(busy_c), .DONE(done_c));
    led_code_scanner #(.TABLE_W(24), .LED_W(8), .DIV(4), .DWELL(2), .GAP(0), .PASSES(1)) u_d (
        .CLK(CLK), .nRST(nRST), .START(start_d), .ABORT(abort_d), .TABLE(table_d),
        .LED_DATA(led_d), .SLICE_IDX(idx_d), .BUSY(busy_d), .DONE(done_d));

    // Expected outputs n edges after the accepted START (edge 0 = START edge).
    // Each slice occupies div*(dwell+gap) edges, the first div*dwell of them lit.
    function automatic exp_t model(input int div, input int dwell, input int gap, input int passes,
                                   input int ns, input int lw, input logic [31:0] tbl, input int n);
        exp_t e;
        int   p;
        int   k;
        e = '0;
        p = div * (dwell + gap);
        if (passes != 0 && n >= p * ns * passes) begin
            e.done = (n == p * ns * passes);
        end else begin
            k      = (n / p) % ns;
            e.idx  = 2'(k);
            e.busy = 1'b1;
            if ((n % p) < div * dwell) e.led = 8'((tbl >> (k * lw)) & ((32'd1 << lw) - 1));
        end
        return e;
    endfunction

    task automatic test_reset;
        exp_t got;
        nRST = 1'b0;
        {start_a, abort_a, start_b, abort_b, start_c, abort_c, start_d, abort_d} = '0;
        table_a = 16'h1111; table_b = 16'h2222; table_c = 16'h3333; table_d = 24'h444444;
        #12;
        got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
        if (got !== exp_t'('0)) begin fails++; $display("FAIL reset_a: got %h want 000", got); end
        got = {4'h0, led_b, idx_b, busy_b, done_b}; checks++;
        if (got !== exp_t'('0)) begin fails++; $display("FAIL reset_b: got %h want 000", got); end
        got = {4'h0, led_c, idx_c, busy_c, done_c}; checks++;
        if (got !== exp_t'('0)) begin fails++; $display("FAIL reset_c: got %h want 000", got); end
        got = {led_d, idx_d, busy_d, done_d}; checks++;
        if (got !== exp_t'('0)) begin fails++; $display("FAIL reset_d: got %h want 000", got); end
        @(negedge CLK); nRST = 1'b1;
        repeat (3) @(negedge CLK);
        got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
        if (got !== exp_t'('0)) begin fails++; $display("FAIL idle_after_reset: got %h want 000", got); end
    endtask

    task automatic test_gap_single;
        exp_t got, e;
        logic [15:0] t;
        for (int r = 0; r < 2; r++) begin
            t = (r == 0) ? 16'hA5C3 : 16'($urandom());
            @(negedge CLK); table_a = t; start_a = 1'b1;
            @(negedge CLK); start_a = 1'b0; table_a = 16'($urandom());
            for (int n = 0; n <= 70; n++) begin
                if (n > 0) @(negedge CLK);
                e = model(4, 3, 1, 1, 4, 4, {16'h0, t}, n);
                got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL gap_single t=%h edge %0d: got {led,idx,busy,done}=%h want %h", t, n, got, e);
                end
            end
        end
    endtask

    task automatic test_nogap_two_pass;
        exp_t got, e;
        logic [15:0] t;
        for (int r = 0; r < 2; r++) begin
            t = (r == 0) ? 16'hA5C3 : 16'($urandom());
            @(negedge CLK); table_b = t; start_b = 1'b1;
            @(negedge CLK); start_b = 1'b0;
            for (int n = 0; n <= 100; n++) begin
                if (n > 0) @(negedge CLK);
                e = model(4, 3, 0, 2, 4, 4, {16'h0, t}, n);
                got = {4'h0, led_b, idx_b, busy_b, done_b}; checks++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL nogap_two_pass t=%h edge %0d: got %h want %h", t, n, got, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t got, e;
        logic [15:0] t;
        t = 16'($urandom());
        @(negedge CLK); table_b = t; start_b = 1'b1;
        @(negedge CLK); start_b = 1'b0;
        for (int n = 0; n <= 100; n++) begin
            if (n > 0) @(negedge CLK);
            e = model(4, 3, 0, 2, 4, 4, {16'h0, t}, n);
            got = {4'h0, led_b, idx_b, busy_b, done_b}; checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL restart_ignored t=%h edge %0d: got %h want %h", t, n, got, e);
            end
            if (n == 20) begin start_b = 1'b1; table_b = 16'hFFFF; end
            if (n == 21) start_b = 1'b0;
        end
    endtask

    task automatic test_continuous_abort;
        exp_t got, e;
        logic [15:0] t;
        int m;
        t = 16'($urandom());
        m = 6 * 64 + int'($urandom_range(0, 63));
        @(negedge CLK); table_c = t; start_c = 1'b1;
        @(negedge CLK); start_c = 1'b0;
        for (int n = 0; n <= m; n++) begin
            if (n > 0) @(negedge CLK);
            e = model(4, 3, 1, 0, 4, 4, {16'h0, t}, n);
            got = {4'h0, led_c, idx_c, busy_c, done_c}; checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL continuous t=%h edge %0d: got %h want %h", t, n, got, e);
            end
        end
        abort_c = 1'b1;
        @(negedge CLK); abort_c = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) @(negedge CLK);
            got = {4'h0, led_c, idx_c, busy_c, done_c}; checks++;
            if (got !== exp_t'('0)) begin
                fails++;
                $display("FAIL continuous_abort +%0d: got %h want 000", n, got);
            end
        end
    endtask

    task automatic test_abort_final;
        exp_t got, e;
        logic [15:0] t;
        t = 16'($urandom());
        @(negedge CLK); table_a = t; start_a = 1'b1;
        @(negedge CLK); start_a = 1'b0;
        for (int n = 0; n <= 63; n++) begin
            if (n > 0) @(negedge CLK);
            e = model(4, 3, 1, 1, 4, 4, {16'h0, t}, n);
            got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
            if (got !== e) begin fails++; $display("FAIL abort_final run edge %0d: got %h want %h", n, got, e); end
        end
        abort_a = 1'b1;
        @(negedge CLK);
        got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
        if (got !== exp_t'('0)) begin fails++; $display("FAIL abort_on_final_tick: got %h want 000", got); end
        // ABORT stays high in IDLE: ignored, and START alongside it still starts a run
        @(negedge CLK);
        got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
        if (got !== exp_t'('0)) begin fails++; $display("FAIL abort_in_idle: got %h want 000", got); end
        t = 16'($urandom());
        table_a = t; start_a = 1'b1;
        @(negedge CLK); start_a = 1'b0; abort_a = 1'b0;
        for (int n = 0; n <= 66; n++) begin
            if (n > 0) @(negedge CLK);
            e = model(4, 3, 1, 1, 4, 4, {16'h0, t}, n);
            got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
            if (got !== e) begin fails++; $display("FAIL start_with_abort edge %0d: got %h want %h", n, got, e); end
        end
    endtask

    task automatic test_reset_mid;
        exp_t got, e;
        logic [15:0] t;
        t = 16'($urandom());
        @(negedge CLK); table_a = t; start_a = 1'b1;
        @(negedge CLK); start_a = 1'b0;
        for (int n = 0; n <= 30; n++) begin
            if (n > 0) @(negedge CLK);
            e = model(4, 3, 1, 1, 4, 4, {16'h0, t}, n);
            got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
            if (got !== e) begin fails++; $display("FAIL reset_mid run edge %0d: got %h want %h", n, got, e); end
        end
        #1 nRST = 1'b0;
        #1;
        got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
        if (got !== exp_t'('0)) begin fails++; $display("FAIL reset_mid_immediate: got %h want 000", got); end
        @(negedge CLK); nRST = 1'b1;
        repeat (3) @(negedge CLK);
        got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
        if (got !== exp_t'('0)) begin fails++; $display("FAIL no_resume_after_reset: got %h want 000", got); end
        table_a = 16'h1234; start_a = 1'b1;
        @(negedge CLK); start_a = 1'b0;
        for (int n = 0; n <= 66; n++) begin
            if (n > 0) @(negedge CLK);
            e = model(4, 3, 1, 1, 4, 4, 32'h1234, n);
            got = {4'h0, led_a, idx_a, busy_a, done_a}; checks++;
            if (got !== e) begin fails++; $display("FAIL post_reset_run edge %0d: got %h want %h", n, got, e); end
        end
    endtask

    task automatic test_wide;
        exp_t got, e;
        logic [23:0] t;
        for (int r = 0; r < 2; r++) begin
            t = (r == 0) ? 24'hC3A55A : 24'($urandom());
            @(negedge CLK); table_d = t; start_d = 1'b1;
            @(negedge CLK); start_d = 1'b0;
            for (int n = 0; n <= 28; n++) begin
                if (n > 0) @(negedge CLK);
                e = model(4, 2, 0, 1, 3, 8, {8'h0, t}, n);
                got = {led_d, idx_d, busy_d, done_d}; checks++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL wide t=%h edge %0d: got %h want %h", t, n, got, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_gap_single();
        test_nogap_two_pass();
        test_back_to_back();
        test_continuous_abort();
        test_abort_final();
        test_reset_mid();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
